// File: rtl/ahb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ahb_master_arbiter
// Description : Round-robin AHB-Lite arbiter with bus lock, sharing one bridge
//               slave port between NUM_MST masters. Optional beat limit under
//               macro ARB_BURST_LIMIT_EN.
// Revision    : 1.0
// ============================================================================
module ahb_master_arbiter #(
  parameter int NUM_MST   = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = 16
) (
  input  logic                        clk,
  input  logic                        Hreset,
  input  logic [NUM_MST-1:0]          Hbusreq,
  input  logic [NUM_MST-1:0]          Hlock,
  input  logic [NUM_MST*ADDR_W-1:0]   Haddr_m,
  input  logic [NUM_MST*2-1:0]        Htrans_m,
  input  logic [NUM_MST-1:0]          Hwrite_m,
  input  logic [NUM_MST*3-1:0]        Hsize_m,
  input  logic [NUM_MST*DATA_W-1:0]   Hwdata_m,
  output logic [NUM_MST-1:0]          Hgrant,
  output logic [$clog2(NUM_MST)-1:0]  Hmaster,
  output logic                        Hmastlock,
  output logic [ADDR_W-1:0]           Haddr,
  output logic [1:0]                  Htrans,
  output logic                        Hwrite,
  output logic [2:0]                  Hsize,
  output logic [DATA_W-1:0]           Hwdata,
  output logic                        Hreadyin,
  input  logic                        Hreadyout,
  input  logic [DATA_W-1:0]           Hrdata,
  input  logic [1:0]                  Hresp,
  output logic                        Hready_m,
  output logic [DATA_W-1:0]           Hrdata_m,
  output logic [1:0]                  Hresp_m
);

  localparam int IDX_W = $clog2(NUM_MST);
  localparam logic [1:0] C_IDLE   = 2'b00;
  localparam logic [1:0] C_BUSY   = 2'b01;
  localparam logic [1:0] C_NONSEQ = 2'b10;
  localparam logic [1:0] C_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    PARK   = 2'd0,
    OWN    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  if (NUM_MST < 2 || NUM_MST > 8 || MAX_BEATS < 1) begin : g_param_check
    $error("ahb_master_arbiter: illegal NUM_MST or MAX_BEATS");
  end

  state_t               r_state, w_state_nxt;
  logic [NUM_MST-1:0]   r_grant, w_grant_nxt;
  logic [IDX_W-1:0]     r_ptr, w_ptr_nxt;
  logic [IDX_W-1:0]     r_hmaster, r_hmaster_d;
  logic                 r_mastlock;

  logic [ADDR_W-1:0]    w_addr  [NUM_MST];
  logic [1:0]           w_trans [NUM_MST];
  logic [2:0]           w_size  [NUM_MST];
  logic [DATA_W-1:0]    w_wdata [NUM_MST];

  logic [1:0]           w_bus_trans;
  logic                 w_pending, w_lock_now, w_other_req, w_limit, w_rearb, w_found;
  logic [NUM_MST-1:0]   w_req_rot;
  logic [IDX_W:0]       w_shamt, w_off, w_win_sum;
  logic [IDX_W-1:0]     w_win;

  for (genvar i = 0; i < NUM_MST; i++) begin : g_unpack
    assign w_addr[i]  = Haddr_m[i*ADDR_W +: ADDR_W];
    assign w_trans[i] = Htrans_m[i*2 +: 2];
    assign w_size[i]  = Hsize_m[i*3 +: 3];
    assign w_wdata[i] = Hwdata_m[i*DATA_W +: DATA_W];
  end

  // Address/control follow the address-phase owner, write data the data-phase owner.
  assign Haddr     = w_addr[r_hmaster];
  assign Htrans    = Hreset ? C_IDLE : w_trans[r_hmaster];
  assign Hwrite    = Hwrite_m[r_hmaster];
  assign Hsize     = w_size[r_hmaster];
  assign Hwdata    = w_wdata[r_hmaster_d];
  assign Hreadyin  = Hreadyout;
  assign Hready_m  = Hreadyout;
  assign Hrdata_m  = Hrdata;
  assign Hresp_m   = Hresp;
  assign Hgrant    = r_grant;
  assign Hmaster   = r_hmaster;
  assign Hmastlock = r_mastlock;

  assign w_bus_trans = w_trans[r_hmaster];
  assign w_pending   = (r_ptr != r_hmaster);
  assign w_lock_now  = Hlock[r_ptr] && ((r_state == LOCKED) || Hbusreq[r_ptr]);
  assign w_other_req = |(Hbusreq & ~r_grant);

`ifdef ARB_BURST_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  logic [CNT_W-1:0] r_beats, w_beats_inc;
  logic             w_beat;

  // Beats issued by the old owner while a handover is pending are not charged.
  assign w_beat      = ((w_bus_trans == C_NONSEQ) || (w_bus_trans == C_SEQ)) && !w_pending;
  assign w_beats_inc = (w_beat && (r_beats < CNT_W'(MAX_BEATS))) ? r_beats + 1'b1 : r_beats;
  assign w_limit     = (w_beats_inc >= CNT_W'(MAX_BEATS)) && w_other_req;

  always_ff @(posedge clk) begin
    if (Hreset) begin
      r_beats <= '0;
    end else if (Hreadyout) begin
      r_beats <= (w_grant_nxt != r_grant) ? '0 : w_beats_inc;
    end
  end
`else
  assign w_limit = 1'b0;
`endif

  always_comb begin
    w_shamt   = {1'b0, r_ptr} + 1'b1;
    w_req_rot = NUM_MST'({Hbusreq, Hbusreq} >> w_shamt);
    w_found   = 1'b0;
    w_off     = '0;
    // Descending scan leaves the lowest set bit, i.e. nearest after the owner.
    for (int j = NUM_MST - 1; j >= 0; j--) begin
      if (w_req_rot[j]) begin
        w_found = 1'b1;
        w_off   = (IDX_W+1)'(j);
      end
    end
    w_win_sum = w_shamt + w_off;
    if (w_win_sum >= (IDX_W+1)'(NUM_MST)) begin
      w_win_sum = w_win_sum - (IDX_W+1)'(NUM_MST);
    end
    w_win = w_win_sum[IDX_W-1:0];
  end

  always_comb begin
    w_rearb     = !w_lock_now && !w_pending &&
                  (((w_bus_trans != C_SEQ) && (w_bus_trans != C_BUSY) &&
                    (!Hbusreq[r_ptr] || (w_bus_trans == C_IDLE))) || w_limit);
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    if (w_rearb && w_found) begin
      w_grant_nxt = NUM_MST'(1) << w_win;
      w_ptr_nxt   = w_win;
    end
    if (w_lock_now) begin
      w_state_nxt = LOCKED;
    end else if (Hbusreq[w_ptr_nxt]) begin
      w_state_nxt = OWN;
    end else begin
      w_state_nxt = PARK;
    end
  end

  always_ff @(posedge clk) begin
    if (Hreset) begin
      r_state     <= PARK;
      r_grant     <= NUM_MST'(1);
      r_ptr       <= '0;
      r_hmaster   <= '0;
      r_hmaster_d <= '0;
      r_mastlock  <= 1'b0;
    end else if (Hreadyout) begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_ptr       <= w_ptr_nxt;
      r_hmaster_d <= r_hmaster;
      r_hmaster   <= r_ptr;
      r_mastlock  <= w_lock_now;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ahb_master_arbiter.sv
`default_nettype none
// Self-checking bench for ahb_master_arbiter: vector table, directed corner
// sequences and randomized traffic against a behavioural arbitration model.
module tb_ahb_master_arbiter;

  localparam int NUM_MST   = 4;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int MAX_BEATS = 4;
  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;
`ifdef ARB_BURST_LIMIT_EN
  localparam int EXP_MOVE = 4;
`else
  localparam int EXP_MOVE = 9;
`endif

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] master;
  } vec_t;

  logic                       clk = 1'b0;
  logic                       Hreset;
  logic [NUM_MST-1:0]         Hbusreq, Hlock, Hwrite_m, Hgrant;
  logic [NUM_MST*ADDR_W-1:0]  Haddr_m;
  logic [NUM_MST*2-1:0]       Htrans_m;
  logic [NUM_MST*3-1:0]       Hsize_m;
  logic [NUM_MST*DATA_W-1:0]  Hwdata_m;
  logic [1:0]                 Hmaster;
  logic                       Hmastlock, Hwrite, Hreadyin, Hreadyout, Hready_m;
  logic [ADDR_W-1:0]          Haddr;
  logic [1:0]                 Htrans, Hresp, Hresp_m;
  logic [2:0]                 Hsize;
  logic [DATA_W-1:0]          Hwdata, Hrdata, Hrdata_m;

  always #5 clk = ~clk;

  ahb_master_arbiter #(
    .NUM_MST(NUM_MST), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS)
  ) dut (
    .clk(clk), .Hreset(Hreset), .Hbusreq(Hbusreq), .Hlock(Hlock),
    .Haddr_m(Haddr_m), .Htrans_m(Htrans_m), .Hwrite_m(Hwrite_m),
    .Hsize_m(Hsize_m), .Hwdata_m(Hwdata_m), .Hgrant(Hgrant),
    .Hmaster(Hmaster), .Hmastlock(Hmastlock), .Haddr(Haddr),
    .Htrans(Htrans), .Hwrite(Hwrite), .Hsize(Hsize), .Hwdata(Hwdata),
    .Hreadyin(Hreadyin), .Hreadyout(Hreadyout), .Hrdata(Hrdata),
    .Hresp(Hresp), .Hready_m(Hready_m), .Hrdata_m(Hrdata_m),
    .Hresp_m(Hresp_m)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state: grant holder, address/data phase owners, lock, beats.
  int m_own, m_hm, m_hmd, m_cnt;
  bit m_lock;
  bit m_valid = 1'b0;

  vec_t       vecs [6];
  logic [3:0] order [$];
  logic [3:0] rr_exp [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
  logic [3:0] last_grant;
  int         prev_hm, beats, move_edge;
  bit         is_beat;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [1:0] trans_of(input int i);
    return Htrans_m[i*2 +: 2];
  endfunction

  task automatic set_trans(input int i, input logic [1:0] t);
    Htrans_m[i*2 +: 2] = t;
  endtask

  // One clock edge of the arbitration rules, applied to the inputs present at the edge.
  task automatic model_step();
    logic [1:0] bt;
    bit pend, lk, lim, rearb;
    int win;
    if (Hreset) begin
      m_own = 0; m_hm = 0; m_hmd = 0; m_lock = 1'b0; m_cnt = 0; m_valid = 1'b1;
      return;
    end
    if (!m_valid || !Hreadyout) return;
    bt   = trans_of(m_hm);
    pend = (m_own != m_hm);
    lk   = Hlock[m_own] && (m_lock || Hbusreq[m_own]);
    lim  = 1'b0;
`ifdef ARB_BURST_LIMIT_EN
    if ((bt == T_NONSEQ || bt == T_SEQ) && !pend) m_cnt++;
    for (int i = 0; i < NUM_MST; i++)
      if (i != m_own && Hbusreq[i] && m_cnt >= MAX_BEATS) lim = 1'b1;
`endif
    rearb = !lk && !pend && ((bt == T_IDLE) || (bt == T_NONSEQ && !Hbusreq[m_own]) || lim);
    win = m_own;
    if (rearb) begin
      for (int k = 1; k <= NUM_MST; k++) begin
        if (Hbusreq[(m_own + k) % NUM_MST]) begin
          win = (m_own + k) % NUM_MST;
          break;
        end
      end
    end
    if (win != m_own) m_cnt = 0;
    m_hmd  = m_hm;
    m_hm   = m_own;
    m_lock = lk;
    m_own  = win;
  endtask

  task automatic check_outputs();
    if (!m_valid) return;
    chk("hgrant",    Hgrant,    64'(1) << m_own);
    chk("hmaster",   Hmaster,   64'(m_hm));
    chk("hmastlock", Hmastlock, 64'(m_lock));
    chk("haddr",     Haddr,     Haddr_m[m_hm*ADDR_W +: ADDR_W]);
    chk("htrans",    Htrans,    Hreset ? T_IDLE : trans_of(m_hm));
    chk("hwrite",    Hwrite,    Hwrite_m[m_hm]);
    chk("hsize",     Hsize,     Hsize_m[m_hm*3 +: 3]);
    chk("hwdata",    Hwdata,    Hwdata_m[m_hmd*DATA_W +: DATA_W]);
    chk("hready",    {Hreadyin, Hready_m}, {Hreadyout, Hreadyout});
    chk("hrdata_m",  Hrdata_m,  Hrdata);
    chk("hresp_m",   Hresp_m,   Hresp);
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    Hreset = 1'b1; Hbusreq = '0; Hlock = '0; Hreadyout = 1'b1; Htrans_m = '0;
    cycle();
    cycle();
    Hreset = 1'b0;
  endtask

  initial begin
    vecs[0] = '{req: 4'b0100, grant: 4'b0100, master: 2'd2};
    vecs[1] = '{req: 4'b0001, grant: 4'b0001, master: 2'd0};
    vecs[2] = '{req: 4'b1010, grant: 4'b0010, master: 2'd1};
    vecs[3] = '{req: 4'b1001, grant: 4'b1000, master: 2'd3};
    vecs[4] = '{req: 4'b0000, grant: 4'b0001, master: 2'd0};
    vecs[5] = '{req: 4'b1100, grant: 4'b0100, master: 2'd2};

    Hreset = 1'b1; Hbusreq = '0; Hlock = '0; Hreadyout = 1'b1;
    Hrdata = 32'h1234_5678; Hresp = 2'b00; Hwrite_m = '0;
    Hsize_m = {3'd2, 3'd2, 3'd2, 3'd2};
    Haddr_m = {32'h8000_0018, 32'h8000_0010, 32'h8000_0008, 32'h8000_0000};
    Hwdata_m = {32'hD3D3_D3D3, 32'hC2C2_C2C2, 32'hB1B1_B1B1, 32'hA0A0_A0A0};
    Htrans_m = {T_NONSEQ, T_NONSEQ, T_NONSEQ, T_NONSEQ};

    // Reset with every master driving NONSEQ.
    cycle();
    cycle();
    chk("rst_htrans", Htrans, T_IDLE);
    chk("rst_hgrant", Hgrant, 4'b0001);
    chk("rst_hmaster", Hmaster, 2'd0);
    chk("rst_hmastlock", Hmastlock, 1'b0);
    Hreset = 1'b0;
    Htrans_m = '0;

    // Single-request grants out of PARK.
    foreach (vecs[v]) begin
      do_reset();
      Hbusreq = vecs[v].req;
      cycle();
      chk("vec_grant", Hgrant, vecs[v].grant);
      cycle();
      chk("vec_master", Hmaster, vecs[v].master);
    end

    // PARK to master 2, first NONSEQ reaches the bridge.
    do_reset();
    Hbusreq = 4'b0100;
    cycle();
    chk("park_grant", Hgrant, 4'b0100);
    cycle();
    chk("park_master", Hmaster, 2'd2);
    set_trans(2, T_NONSEQ);
    #1;
    chk("park_haddr", Haddr, 32'h8000_0010);
    chk("park_htrans", Htrans, T_NONSEQ);
    cycle();
    set_trans(2, T_IDLE);

    // Round robin, each owner one NONSEQ then IDLE.
    do_reset();
    Hbusreq = 4'b1111;
    prev_hm = 0;
    last_grant = Hgrant;
    order.delete();
    for (int c = 0; c < 40 && order.size() < 5; c++) begin
      for (int i = 0; i < NUM_MST; i++)
        set_trans(i, (int'(Hmaster) == i && prev_hm != i) ? T_NONSEQ : T_IDLE);
      prev_hm = int'(Hmaster);
      cycle();
      if (Hgrant != last_grant) begin
        order.push_back(Hgrant);
        last_grant = Hgrant;
      end
    end
    for (int k = 0; k < 5; k++)
      chk("rr_order", (k < order.size()) ? order[k] : 4'b0000, rr_exp[k]);
    Htrans_m = '0;

    // Wait states freeze the pipeline; write data of master 1 held.
    do_reset();
    Hbusreq = 4'b0010;
    cycle();
    cycle();
    set_trans(1, T_NONSEQ);
    Hwrite_m[1] = 1'b1;
    Hwdata_m[DATA_W +: DATA_W] = 32'hDEAD_BEEF;
    Hbusreq = 4'b0110;
    cycle();
    set_trans(1, T_IDLE);
    Hreadyout = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("wait_grant", Hgrant, 4'b0010);
      chk("wait_master", Hmaster, 2'd1);
      chk("wait_hwdata", Hwdata, 32'hDEAD_BEEF);
    end
    Hreadyout = 1'b1;
    cycle();
    chk("wait_handover", Hgrant, 4'b0100);
    Hwrite_m[1] = 1'b0;

    // Locked master 1 keeps the grant through IDLE gaps.
    do_reset();
    Hbusreq = 4'b0010;
    Hlock = 4'b0010;
    cycle();
    cycle();
    Hbusreq = 4'b1010;
    for (int k = 0; k < 6; k++) begin
      set_trans(1, (k % 2 == 0) ? T_NONSEQ : T_IDLE);
      cycle();
      chk("lock_grant", Hgrant, 4'b0010);
      chk("lock_mastlock", Hmastlock, 1'b1);
    end
    Hlock = 4'b0000;
    set_trans(1, T_IDLE);
    cycle();
    chk("unlock_grant", Hgrant, 4'b1000);
    chk("unlock_mastlock", Hmastlock, 1'b0);

    // 8-beat INCR from master 0 with master 1 waiting.
    do_reset();
    Hbusreq = 4'b0001;
    cycle();
    Hbusreq = 4'b0011;
    beats = 0;
    move_edge = 0;
    for (int e = 1; e <= 12; e++) begin
      is_beat = Hgrant[0] && (beats < 8);
      set_trans(0, !is_beat ? T_IDLE : (beats == 0) ? T_NONSEQ : T_SEQ);
      cycle();
      if (is_beat) beats++;
      if (Hgrant == 4'b0010 && move_edge == 0) move_edge = e;
    end
    chk("burst_move_edge", 64'(move_edge), 64'(EXP_MOVE));
    Htrans_m = '0;
    Hbusreq = '0;

    // Randomized traffic, including wait states, locks, errors and resets.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      Hreset    = ($urandom_range(0, 99) == 0);
      Hreadyout = ($urandom_range(0, 9) < 8);
      Hbusreq   = 4'($urandom);
      Hlock     = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      Htrans_m  = 8'($urandom);
      Hwrite_m  = 4'($urandom);
      Hsize_m   = 12'($urandom);
      Haddr_m   = {$urandom, $urandom, $urandom, $urandom};
      Hwdata_m  = {$urandom, $urandom, $urandom, $urandom};
      Hrdata    = $urandom;
      Hresp     = 2'($urandom);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ahb_master_arbiter.md
Name: ahb_master_arbiter

Overview:
- Shares the single AHB-Lite slave port of the AHB2APB bridge between NUM_MST AHB masters (CPU, DMA, bench agents).
- Round-robin grant with bus lock. Muxes the address/control of the address-phase owner and Hwdata of the data-phase owner onto the bridge. Broadcasts Hreadyout/Hrdata/Hresp back to all masters.
- Sits between master interfaces and the bridge slave port; one arbiter per bridge.

Parameters:
- NUM_MST, 4, number of masters (2..8)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_BEATS, 16, beats accepted before forced re-arbitration (only with ARB_BURST_LIMIT_EN)

Ports:
- clk  in  1  bus clock; all state on posedge
- Hreset  in  1  synchronous reset, active-high
- Hbusreq  in  NUM_MST  per-master bus request
- Hlock  in  NUM_MST  per-master lock request
- Haddr_m  in  NUM_MST*ADDR_W  packed master addresses, master i at [i*ADDR_W +: ADDR_W]
- Htrans_m  in  NUM_MST*2  packed master Htrans
- Hwrite_m  in  NUM_MST  master Hwrite
- Hsize_m  in  NUM_MST*3  packed master Hsize
- Hwdata_m  in  NUM_MST*DATA_W  packed master write data
- Hgrant  out  NUM_MST  one-hot grant, registered
- Hmaster  out  clog2(NUM_MST)  address-phase owner index, registered
- Hmastlock  out  1  current owner holds lock
- Haddr  out  ADDR_W  to bridge
- Htrans  out  2  to bridge
- Hwrite  out  1  to bridge
- Hsize  out  3  to bridge
- Hwdata  out  DATA_W  to bridge, data-phase owner
- Hreadyin  out  1  to bridge, equals Hreadyout
- Hreadyout  in  1  from bridge
- Hrdata  in  DATA_W  from bridge
- Hresp  in  2  from bridge
- Hready_m  out  1  broadcast Hreadyout to masters
- Hrdata_m  out  DATA_W  broadcast Hrdata
- Hresp_m  out  2  broadcast Hresp

Behaviour:
- Clock/reset: single clock clk. Hreset is synchronous and active-high.
- Reset values: Hgrant=1 (master 0), Hmaster=0, data owner Hmaster_d=0, Hmastlock=0, state PARK, rr pointer=0, beat counter=0. While Hreset=1, Htrans is forced to 2'b00.
- Address mux: Haddr/Htrans/Hwrite/Hsize are combinational from master Hmaster. Hwdata is combinational from Hmaster_d.
- Pipeline advance: state updates only on edges with Hreadyout=1.
  - At such an edge: Hmaster_d<=Hmaster, then Hmaster<=index of Hgrant.
  - With Hreadyout=0, Hgrant/Hmaster/Hmaster_d/counters hold.
- Handover: grant moves at edge E1; the address mux follows at the next Hreadyout-high edge E2.
  - Between E1 and E2 the old owner still drives the bus and must drive IDLE.
  - Minimum request-to-NONSEQ latency from PARK: 2 cycles.
- States:
  - PARK: no Hbusreq set. Grant stays on last owner.
  - OWN: grant owner requesting, unlocked.
  - LOCKED: grant owner has Hlock=1. Hmastlock=1 while Hmaster is the locking master.
- Re-arbitration: at a Hreadyout-high edge when state!=LOCKED, Hgrant==onehot(Hmaster) (no handover pending), and any of:
  - owner Hbusreq=0
  - bus Htrans==IDLE(00)
  - beat limit reached
- Winner: first requester searching from (owner+1) mod NUM_MST, wrapping. The owner itself is the last candidate.
  - No requesters: go to PARK, grant unchanged.
- Transfer boundaries: grant never moves while bus Htrans is SEQ(11) or BUSY(01), except on the beat-limit rule.
- Lock:
  - LOCKED is entered when the grant owner has Hbusreq=1 and Hlock=1 at a Hreadyout-high edge.
  - LOCKED is left on the first Hreadyout-high edge with owner Hlock=0. Normal re-arbitration applies on that same edge.
- Simultaneous requests: resolved in one edge by the round-robin order. New requests arriving during a handover wait for the next evaluation.
- Hresp ERROR: passed through unchanged. No arbitration effect.
- Reset mid-transfer: all state returns to reset values on the next edge regardless of Hreadyout. In-flight data phase is dropped.

Optional Feature:
- Macro: ARB_BURST_LIMIT_EN.
- Defined:
  - Counter increments on each Hreadyout-high edge with bus Htrans NONSEQ or SEQ. It resets on grant change or NONSEQ from a new owner.
  - When count reaches MAX_BEATS and another master requests, re-arbitration is forced even mid-SEQ. The owner sees the grant loss and must re-issue the remainder as NONSEQ.
  - Ignored in LOCKED.
- Undefined: no counter; grant moves only at transfer boundaries as above.

Test Plan:
- Reset: Hreset=1 for 2 cycles, masters driving NONSEQ -> Htrans=00, Hgrant=4'b0001, Hmaster=0, Hmastlock=0.
- PARK to single request: Hbusreq=4'b0100 -> Hgrant=4'b0100 after 1 edge; Hmaster=2 after next edge; Haddr=0x8000_0010 with Htrans=NONSEQ from master 2.
- Round robin: all four request, each does one NONSEQ then IDLE, owner starts at 0 -> grant order 1,2,3,0,1.
- Wait states: master 1 write with Hwdata_m[1]=0xDEADBEEF, Hreadyout=0 for 3 cycles, master 2 requesting -> Hgrant/Hmaster/Hmaster_d frozen; Hwdata=0xDEADBEEF throughout; handover after Hreadyout=1.
- Lock: master 1 Hlock=1 with IDLE gaps, master 3 requesting -> grant stays 4'b0010 and Hmastlock=1 until Hlock drops; master 3 granted on that edge.
- Burst limit, MAX_BEATS=4: master 0 8-beat INCR, master 1 requesting -> with ARB_BURST_LIMIT_EN, grant moves to master 1 after the 4th beat is accepted; without the macro, after the 8th.
